// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// Every signal is a plain per-cycle level with no valid/ready handshake:
// hazard inputs are sampled combinationally each cycle, and control outputs
// are acted on by the pipeline registers at the next posedge.
// The master side is the datapath and the slave side is the controller.
interface pipe_hazard_ctrl_if #(
  parameter int PERF_W = 32
);
  logic              IDEX_MemRead_i;
  logic [4:0]        IDEX_RtAddr_i;
  logic [4:0]        IFID_RsAddr_i;
  logic [4:0]        IFID_RtAddr_i;
  logic              Branch_taken_i;
  logic              Dmem_busy_i;
  logic              PC_Write_o;
  logic              IFID_Write_o;
  logic              IFID_Flush_o;
  logic              IDEX_Bubble_o;
  logic              Freeze_o;
  logic [1:0]        State_o;
  logic [PERF_W-1:0] Stall_cnt_o;
  logic [PERF_W-1:0] Flush_cnt_o;

  modport master (
    output IDEX_MemRead_i, IDEX_RtAddr_i, IFID_RsAddr_i, IFID_RtAddr_i,
    output Branch_taken_i, Dmem_busy_i,
    input  PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Freeze_o,
    input  State_o, Stall_cnt_o, Flush_cnt_o
  );

  modport slave (
    input  IDEX_MemRead_i, IDEX_RtAddr_i, IFID_RsAddr_i, IFID_RtAddr_i,
    input  Branch_taken_i, Dmem_busy_i,
    output PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Freeze_o,
    output State_o, Stall_cnt_o, Flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// It handles three hazards: data-memory wait, load-use, and taken branch.
// Outputs are Mealy so a stall takes effect in the cycle its hazard is seen.
// Optional macro PERF_CNT_EN adds saturating stall/flush cycle counters.
// Without that macro, the counter ports are tied to zero.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int PERF_W       = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] flush_cnt_q, flush_cnt_d;
  logic       lu;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, freeze;

  // A load into $0 never creates a dependency.
  assign lu = hz.IDEX_MemRead_i && (hz.IDEX_RtAddr_i != 5'd0) &&
              ((hz.IDEX_RtAddr_i == hz.IFID_RsAddr_i) ||
               (hz.IDEX_RtAddr_i == hz.IFID_RtAddr_i));

  // Next-state and Mealy control outputs; priority is busy, then lu, then branch.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    freeze      = 1'b0;
    if (rst_i) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          if (hz.Dmem_busy_i) begin
            // Flush sequence pauses with its count intact.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            freeze     = 1'b1;
          end else begin
            // ID holds a flushed slot, so lu and branch are meaningless here.
            ifid_flush  = 1'b1;
            flush_cnt_d = flush_cnt_q - 2'd1;
            if (flush_cnt_q == 2'd1) state_d = ST_RUN;
          end
        end
        default: begin
          // RUN and the release cycle of MEM_WAIT share the same decision.
          if (hz.Dmem_busy_i) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            freeze     = 1'b1;
            state_d    = ST_MEM_WAIT;
          end else if (lu) begin
            // One bubble; a branch in ID is ignored since its operand is stale.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_d     = ST_RUN;
          end else if (hz.Branch_taken_i) begin
            ifid_flush = 1'b1;
            if (FLUSH_CYCLES == 1) begin
              state_d = ST_RUN;
            end else begin
              flush_cnt_d = 2'(FLUSH_CYCLES - 1);
              state_d     = ST_FLUSH;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
      endcase
    end
  end

  // State and flush counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.PC_Write_o    = pc_write;
  assign hz.IFID_Write_o  = ifid_write;
  assign hz.IFID_Flush_o  = ifid_flush;
  assign hz.IDEX_Bubble_o = idex_bubble;
  assign hz.Freeze_o      = freeze;
  assign hz.State_o       = state_q;

`ifdef PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_pc_q;
  logic              stall_evt, flush_evt;

  // lu only stalls outside FLUSH and when memory is not busy.
  assign stall_evt = !rst_i && (hz.Dmem_busy_i || (lu && (state_q != ST_FLUSH)));
  assign flush_evt = !rst_i && ifid_flush;

  // Saturating performance counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_pc_q  <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_evt && (flush_pc_q != '1))  flush_pc_q  <= flush_pc_q + 1'b1;
    end
  end

  assign hz.Stall_cnt_o = stall_cnt_q;
  assign hz.Flush_cnt_o = flush_pc_q;
`else
  assign hz.Stall_cnt_o = '0;
  assign hz.Flush_cnt_o = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It sits beside the IF/ID and ID/EX pipeline registers and the PC. Each cycle it decides whether the front end advances, holds, or is flushed, and whether ID/EX receives a bubble. Three hazard sources are handled: data-memory wait, load-use dependency, and taken branch (resolved in ID).

Parameters:
FLUSH_CYCLES, 1, number of consecutive cycles IF/ID is flushed after a taken branch; legal range 1..3.
PERF_W, 32, width of performance counters (used only with PERF_CNT_EN).

Ports:
clk_i  in  1  clock; all state updates on posedge.
rst_i  in  1  synchronous, active-high reset.
IDEX_MemRead_i  in  1  instruction in EX is a load.
IDEX_RtAddr_i  in  5  load destination register in EX.
IFID_RsAddr_i  in  5  rs of the instruction in ID.
IFID_RtAddr_i  in  5  rt of the instruction in ID.
Branch_taken_i  in  1  branch in ID resolved taken this cycle.
Dmem_busy_i  in  1  data memory not ready; whole pipeline must hold.
PC_Write_o  out  1  1 = PC updates.
IFID_Write_o  out  1  1 = IF/ID loads.
IFID_Flush_o  out  1  1 = IF/ID loads a NOP.
IDEX_Bubble_o  out  1  1 = ID/EX loads zeroed WB/MEM/EX control.
Freeze_o  out  1  1 = ID/EX, EX/MEM and MEM/WB hold their contents.
State_o  out  2  current state (debug): 0 RUN, 1 FLUSH, 2 MEM_WAIT.
Stall_cnt_o  out  PERF_W  load-use plus memory-wait stall cycles.
Flush_cnt_o  out  PERF_W  branch flush cycles.

Behaviour:
- Outputs are Mealy (combinational from registered state and current inputs), so a stall acts in the same cycle its hazard is seen. State, flush counter and perf counters are registered.
- While rst_i=1, outputs are forced to PC_Write_o=0, IFID_Write_o=0, IFID_Flush_o=1, IDEX_Bubble_o=1, Freeze_o=0.
- On the posedge with rst_i=1: state becomes RUN, flush_cnt becomes 0, perf counters become 0. This also applies when reset arrives mid-flush or mid-wait.
- Default outputs, with no hazard: PC_Write_o=1, IFID_Write_o=1, IFID_Flush_o=0, IDEX_Bubble_o=0, Freeze_o=0.
- Load-use hazard (lu): IDEX_MemRead_i=1, IDEX_RtAddr_i!=0, and IDEX_RtAddr_i equals IFID_RsAddr_i or IFID_RtAddr_i.
- Priority, highest first: Dmem_busy_i, then lu, then Branch_taken_i.
- RUN state:
  - Dmem_busy_i: PC_Write_o=0, IFID_Write_o=0, Freeze_o=1, no bubble; next state MEM_WAIT.
  - lu: PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=1; stay in RUN. This gives exactly one stall cycle per load-use. Branch_taken_i is ignored in this cycle because the branch operand is not yet valid.
  - Branch_taken_i: PC_Write_o=1, IFID_Flush_o=1. If FLUSH_CYCLES=1, stay in RUN. Otherwise load flush_cnt=FLUSH_CYCLES-1 and go to FLUSH.
- FLUSH state:
  - IFID_Flush_o=1, PC_Write_o=1.
  - Branch_taken_i and lu are ignored, since ID holds a flushed slot.
  - flush_cnt decrements each cycle; go to RUN when it reaches 0.
  - If Dmem_busy_i=1: freeze outputs as in MEM_WAIT, flush_cnt holds, and state stays FLUSH.
- MEM_WAIT state:
  - Freeze outputs (PC_Write_o=0, IFID_Write_o=0, Freeze_o=1) for as long as Dmem_busy_i=1.
  - In the first cycle with Dmem_busy_i=0, evaluate exactly as in RUN (lu and branch apply) and return to RUN.
  - A zero-length wait is not possible, since entry requires busy=1.
- Freeze_o and IDEX_Bubble_o are never both 1.

Optional Feature:
PERF_CNT_EN
- Defined:
  - Stall_cnt_o increments on every cycle with (Dmem_busy_i or lu-stall) and rst_i=0.
  - Flush_cnt_o increments on every cycle with IFID_Flush_o=1 and rst_i=0.
  - Both counters saturate at all-ones and do not wrap.
- Undefined: both ports are present, driven constant 0, and no counter flops are inferred.

Test Plan:
1. Load-use: IDEX_MemRead_i=1, IDEX_RtAddr_i=8, IFID_RsAddr_i=8 for 1 cycle -> that cycle PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=1; next cycle (MemRead_i=0) all defaults. With PERF_CNT_EN, Stall_cnt_o=1.
2. Load to $0: IDEX_RtAddr_i=0, IFID_RsAddr_i=0, MemRead_i=1 -> no stall; default outputs.
3. Branch with FLUSH_CYCLES=2: Branch_taken_i=1 one cycle -> IFID_Flush_o=1 for exactly 2 cycles, State_o goes 0→1→0; a second Branch_taken_i in the FLUSH cycle is ignored.
4. Memory wait: Dmem_busy_i=1 for 3 cycles -> Freeze_o=1, PC_Write_o=0 for those 3 cycles, State_o=2 from cycle 2. Then release with lu present -> that cycle bubble=1, Freeze_o=0.
5. Busy during flush (FLUSH_CYCLES=3): branch, then busy=1 for 2 cycles in FLUSH -> flush pauses and total IFID_Flush_o cycles still equal 3.
6. Reset mid-MEM_WAIT: assert rst_i for 1 cycle while busy=1 -> outputs forced to reset values; after release, State_o=0 and counters=0.
